// File: rtl/fpdiv.sv
// Iterative 11-bit floating-point divider {sign, exp, frac}: one divide in flight, fixed 11-cycle latency.
// Define FPDIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fpdiv #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 6,
  parameter int BIAS  = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  output logic [EXP_W+MAN_W:0]       quotient,
  output logic                       done,
  output logic                       busy,
  output logic                       ovf,
  output logic                       dz
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;          // mantissa including hidden bit
  localparam int QW = MAN_W + 3;          // integer bit + fraction + guard + one sticky bit
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  state_t                state_r;
  logic [CW-1:0]         cnt_r;
  logic [W-1:0]          a_r;
  logic [W-1:0]          b_r;
  logic [MW:0]           rem_r;
  logic [QW-1:0]         q_r;
  logic signed [EW-1:0]  e_r;

  logic [MW-1:0]         mb_s;
  logic                  ge_s;
  logic [MW-1:0]         diff_s;
  logic                  sign_s;
  logic [MAN_W-1:0]      frac_s;
  logic signed [EW-1:0]  e_n_s;
  logic [W-1:0]          res_s;
  logic                  ovf_s;
  logic                  dz_s;
`ifdef FPDIV_ROUND_EN
  logic                  guard_s;
  logic                  sticky_s;
  logic                  carry_s;
`endif

  // One restoring-division step plus normalize/round/exception handling of the finished quotient.
  always_comb begin
    mb_s   = {1'b1, b_r[MAN_W-1:0]};
    ge_s   = (rem_r >= {1'b0, mb_s});
    diff_s = ge_s ? MW'(rem_r - {1'b0, mb_s}) : rem_r[MW-1:0];
    sign_s = a_r[W-1] ^ b_r[W-1];
    ovf_s  = 1'b0;
    dz_s   = 1'b0;
    if (q_r[QW-1]) begin
      frac_s = q_r[QW-2 -: MAN_W];
      e_n_s  = e_r;
    end else begin
      frac_s = q_r[QW-3 -: MAN_W];
      e_n_s  = e_r - EW'(1);
    end
`ifdef FPDIV_ROUND_EN
    guard_s  = q_r[QW-1] ? q_r[1] : q_r[0];
    sticky_s = (q_r[QW-1] & q_r[0]) | (|rem_r);
    {carry_s, frac_s} = {1'b0, frac_s} + (MAN_W+1)'(guard_s & (sticky_s | frac_s[0]));
    if (carry_s) begin
      e_n_s = e_n_s + EW'(1);
    end else begin
      e_n_s = e_n_s;
    end
`endif
    res_s = {sign_s, e_n_s[EXP_W-1:0], frac_s};
    if (b_r[W-2 -: EXP_W] == {EXP_W{1'b0}}) begin
      res_s = {sign_s, {(W-1){1'b1}}};
      dz_s  = 1'b1;
    end else if (a_r[W-2 -: EXP_W] == {EXP_W{1'b0}}) begin
      res_s = {sign_s, {(W-1){1'b0}}};
    end else if (e_n_s > $signed(EW'((1 << EXP_W) - 1))) begin
      res_s = {sign_s, {(W-1){1'b1}}};
      ovf_s = 1'b1;
    end else if (e_n_s < $signed(EW'(1))) begin
      res_s = {sign_s, {(W-1){1'b0}}};
    end else begin
      res_s = res_s;
    end
  end

  // Control FSM: capture, setup + one quotient bit per cycle, then register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      rem_r    <= {(MW+1){1'b0}};
      q_r      <= {QW{1'b0}};
      e_r      <= {EW{1'b0}};
      quotient <= {W{1'b0}};
      done     <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_ready) begin
            a_r     <= a;
            b_r     <= b;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= DIV;
          end
        end
        DIV: begin
          // Count 0 loads the dividend and exponent; counts 1..QW each retire one quotient bit.
          if (cnt_r == {CW{1'b0}}) begin
            rem_r <= {1'b0, 1'b1, a_r[MAN_W-1:0]};
            q_r   <= {QW{1'b0}};
            e_r   <= EW'({2'b00, a_r[W-2 -: EXP_W]}) - EW'({2'b00, b_r[W-2 -: EXP_W]}) + EW'(BIAS);
          end else begin
            rem_r <= {diff_s, 1'b0};
            q_r   <= {q_r[QW-2:0], ge_s};
          end
          if (cnt_r == CW'(QW)) begin
            state_r <= NORM;
          end
          cnt_r <= cnt_r + CW'(1);
        end
        NORM: begin
          quotient <= res_s;
          ovf      <= ovf_s;
          dz       <= dz_s;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
